// File: rtl/column_drop_pkg.sv
// Shared definitions for the 7x6 column-drop game controller.
//   COLS, ROWS  : default board geometry
//   MAX_MOVES   : cells on a full board (game ends after this many moves)
//   COL_W       : width of column/row indices and height counters
//   cell_t      : stored cell contents
//   state_t     : controller FSM states
package column_drop_pkg;

  localparam int COLS      = 7;
  localparam int ROWS      = 6;
  localparam int MAX_MOVES = COLS * ROWS;
  localparam int COL_W     = 3;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    P1    = 2'b01,
    P2    = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PENDING = 2'b01,
    DONE    = 2'b10
  } state_t;

endpackage

// File: rtl/key_edge_arbiter.sv
// Rising-edge detector and lowest-index arbiter for the column keys.
//   clk, reset : pixel clock, synchronous active-high reset
//   key_in     : raw column keys, already synchronized to clk
//   req        : at least one key rose this cycle
//   req_col    : lowest-index column whose key rose (valid with req)
module key_edge_arbiter
  import column_drop_pkg::*;
#(
  parameter int COLS = column_drop_pkg::COLS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [COLS-1:0]  key_in,
  output logic             req,
  output logic [COL_W-1:0] req_col
);

  logic [COLS-1:0] key_prev;
  logic [COLS-1:0] rise;

  // Resetting to all ones means a key held down through reset looks like
  // it was already pressed, so releasing reset never manufactures a press.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) key_prev <= '1;
    else       key_prev <= key_in;
  end

  assign rise = key_in & ~key_prev;

  // Scan from the top down so the lowest set index is the last write.
  // NOTE: req_col gets a default before the loop; without it a cycle with
  // no rise would leave it unassigned and infer a latch.
  always_comb begin
    req     = |rise;
    req_col = '0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (rise[i]) req_col = COL_W'(i);
    end
  end

endmodule

// File: rtl/column_drop_controller.sv
// Game-state controller for the column-drop board.
// Accepts one key press at a time, holds it as a pending (highlighted)
// column, and commits the piece only on frame_end so the drawer never sees
// the board change mid-frame.
//   clk, reset  : pixel clock, synchronous active-high reset
//   key_in      : column keys (active-high, synchronized)
//   frame_end   : one-cycle pulse at start of vertical blanking
//   rd_col/row  : combinational cell read address (row 0 = bottom)
//   rd_cell     : cell contents, EMPTY for out-of-range addresses
//   highlight   : one-hot pending column, 0 when nothing pending
//   turn        : 0 = player 1 to move, 1 = player 2
//   move_count  : pieces placed so far
//   move_valid  : one-cycle pulse the cycle after a commit
//   move_col    : column of the last committed move
//   board_full  : game over, every cell occupied
module column_drop_controller
  import column_drop_pkg::*;
#(
  parameter int COLS = column_drop_pkg::COLS,
  parameter int ROWS = column_drop_pkg::ROWS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [COLS-1:0]  key_in,
  input  logic             frame_end,
  input  logic [COL_W-1:0] rd_col,
  input  logic [COL_W-1:0] rd_row,
  output logic [1:0]       rd_cell,
  output logic [COLS-1:0]  highlight,
  output logic             turn,
  output logic [5:0]       move_count,
  output logic             move_valid,
  output logic [COL_W-1:0] move_col,
  output logic             board_full
);

  localparam int TOTAL_CELLS = COLS * ROWS;

  state_t           state;
  logic [COL_W-1:0] pend_col;
  logic [COL_W-1:0] h [COLS];
  cell_t            board [COLS][ROWS];

  logic             req;
  logic [COL_W-1:0] req_col;
  logic             req_col_full;
  logic [5:0]       count_next;

  key_edge_arbiter #(.COLS(COLS)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .key_in  (key_in),
    .req     (req),
    .req_col (req_col)
  );

  assign req_col_full = (h[req_col] == COL_W'(ROWS));
  assign count_next   = move_count + 6'd1;

  // NOTE: the board is cleared by reset on purpose: it is flop storage that
  // the drawer reads directly, so it must show an empty board after reset
  // rather than whatever was left from the previous game.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pend_col   <= '0;
      turn       <= 1'b0;
      move_count <= '0;
      move_valid <= 1'b0;
      move_col   <= '0;
      for (int c = 0; c < COLS; c++) begin
        h[c] <= '0;
        for (int r = 0; r < ROWS; r++) board[c][r] <= EMPTY;
      end
    end else begin
      move_valid <= 1'b0;
      case (state)
        // frame_end is deliberately ignored here: a press arriving with
        // frame_end waits for the following frame to commit.
        IDLE: begin
          if (req && !req_col_full) begin
            pend_col <= req_col;
            state    <= PENDING;
          end
        end
        // Further presses are ignored until the pending move commits.
        PENDING: begin
          if (frame_end) begin
            board[pend_col][h[pend_col]] <= turn ? P2 : P1;
            h[pend_col]                  <= h[pend_col] + 1'b1;
            move_count                   <= count_next;
            turn                         <= ~turn;
            move_col                     <= pend_col;
            move_valid                   <= 1'b1;
            state <= (count_next == 6'(TOTAL_CELLS)) ? DONE : IDLE;
          end
        end
        DONE:    ;
        default: state <= IDLE;
      endcase
    end
  end

  assign highlight  = (state == PENDING) ? (COLS'(1) << pend_col) : '0;
  assign board_full = (state == DONE);

  always_comb begin
    rd_cell = EMPTY;
    if (rd_col < COL_W'(COLS) && rd_row < COL_W'(ROWS)) rd_cell = board[rd_col][rd_row];
  end

endmodule

// File: tb/tb_column_drop_controller.sv
// Directed testbench for column_drop_controller: a vector table for the
// basic press/commit flow plus hand-written sequences for the corner cases.
module tb_column_drop_controller;
  import column_drop_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] key_in;
  logic       frame_end;
  logic [2:0] rd_col, rd_row;
  logic [1:0] rd_cell;
  logic [6:0] highlight;
  logic       turn;
  logic [5:0] move_count;
  logic       move_valid;
  logic [2:0] move_col;
  logic       board_full;

  int n_tests = 0;
  int n_fail  = 0;

  column_drop_controller dut (
    .clk        (clk),
    .reset      (reset),
    .key_in     (key_in),
    .frame_end  (frame_end),
    .rd_col     (rd_col),
    .rd_row     (rd_row),
    .rd_cell    (rd_cell),
    .highlight  (highlight),
    .turn       (turn),
    .move_count (move_count),
    .move_valid (move_valid),
    .move_col   (move_col),
    .board_full (board_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] key;
    logic       fe;
    logic [6:0] exp_hl;
    logic       exp_mv;
    logic [2:0] exp_mc;
    logic       exp_turn;
    logic [5:0] exp_cnt;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs at the falling edge, let one rising edge sample them,
  // then settle #1 so outputs reflect that edge.
  task automatic step(input logic [6:0] key, input logic fe);
    @(negedge clk);
    key_in    = key;
    frame_end = fe;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [6:0] key);
    @(negedge clk);
    reset     = 1'b1;
    key_in    = key;
    frame_end = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic read_cell(input int c, input int r, input logic [1:0] exp, input string name);
    rd_col = 3'(c);
    rd_row = 3'(r);
    #1;
    check(name, 32'(rd_cell), 32'(exp));
  endtask

  // Press, release, commit on frame_end; checks the commit pulse and column.
  task automatic move(input int c, input string name);
    step(7'(1) << c, 1'b0);
    step(7'd0, 1'b0);
    step(7'd0, 1'b1);
    check({name, "_mv"},  32'(move_valid), 32'd1);
    check({name, "_col"}, 32'(move_col),   32'(c));
  endtask

  initial begin
    reset = 1'b1; key_in = '0; frame_end = 1'b0; rd_col = '0; rd_row = '0;

    // key, fe, exp_hl, exp_mv, exp_mc, exp_turn, exp_cnt
    vecs[0] = '{7'b0000000, 1'b0, 7'b0000000, 1'b0, 3'd0, 1'b0, 6'd0};
    vecs[1] = '{7'b0000100, 1'b0, 7'b0000100, 1'b0, 3'd0, 1'b0, 6'd0};
    vecs[2] = '{7'b0000000, 1'b0, 7'b0000100, 1'b0, 3'd0, 1'b0, 6'd0};
    vecs[3] = '{7'b0000000, 1'b1, 7'b0000000, 1'b1, 3'd2, 1'b1, 6'd1};
    vecs[4] = '{7'b0000000, 1'b0, 7'b0000000, 1'b0, 3'd2, 1'b1, 6'd1};
    vecs[5] = '{7'b1010010, 1'b0, 7'b0000010, 1'b0, 3'd2, 1'b1, 6'd1};
    vecs[6] = '{7'b1010010, 1'b0, 7'b0000010, 1'b0, 3'd2, 1'b1, 6'd1};
    vecs[7] = '{7'b0000000, 1'b1, 7'b0000000, 1'b1, 3'd1, 1'b0, 6'd2};
    vecs[8] = '{7'b0000000, 1'b0, 7'b0000000, 1'b0, 3'd1, 1'b0, 6'd2};
    vecs[9] = '{7'b0000000, 1'b1, 7'b0000000, 1'b0, 3'd1, 1'b0, 6'd2};

    do_reset(7'd0);
    #1;
    check("rst_hl",   32'(highlight),  32'd0);
    check("rst_mv",   32'(move_valid), 32'd0);
    check("rst_turn", 32'(turn),       32'd0);
    check("rst_cnt",  32'(move_count), 32'd0);
    check("rst_full", 32'(board_full), 32'd0);

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].key, vecs[i].fe);
      check($sformatf("v%0d_hl", i),   32'(highlight),  32'(vecs[i].exp_hl));
      check($sformatf("v%0d_mv", i),   32'(move_valid), 32'(vecs[i].exp_mv));
      check($sformatf("v%0d_mc", i),   32'(move_col),   32'(vecs[i].exp_mc));
      check($sformatf("v%0d_turn", i), 32'(turn),       32'(vecs[i].exp_turn));
      check($sformatf("v%0d_cnt", i),  32'(move_count), 32'(vecs[i].exp_cnt));
      check($sformatf("v%0d_full", i), 32'(board_full), 32'd0);
    end
    read_cell(2, 0, 2'b01, "c2r0");
    read_cell(1, 0, 2'b10, "c1r0");
    read_cell(4, 0, 2'b00, "c4r0");
    read_cell(6, 0, 2'b00, "c6r0");
    read_cell(7, 0, 2'b00, "oob_col");
    read_cell(2, 6, 2'b00, "oob_row");

    // Column 3 filled with six alternating moves; turn is P1 here.
    for (int i = 0; i < 6; i++) move(3, $sformatf("c3m%0d", i));
    for (int r = 0; r < 6; r++)
      read_cell(3, r, (r % 2 == 0) ? 2'b01 : 2'b10, $sformatf("c3r%0d", r));
    step(7'b0001000, 1'b0);
    check("full_col_hl", 32'(highlight), 32'd0);
    step(7'd0, 1'b1);
    check("full_col_mv",  32'(move_valid), 32'd0);
    check("full_col_cnt", 32'(move_count), 32'd8);

    // Second press while pending is ignored.
    step(7'b0000001, 1'b0);
    check("p0_hl", 32'(highlight), 32'b0000001);
    step(7'd0, 1'b0);
    step(7'b0100000, 1'b0);
    check("p5_ignored_hl", 32'(highlight), 32'b0000001);
    step(7'd0, 1'b1);
    check("p0_mc", 32'(move_col), 32'd0);
    read_cell(0, 0, 2'b01, "c0r0");
    read_cell(5, 0, 2'b00, "c5r0");
    check("p0_cnt", 32'(move_count), 32'd9);

    // Key held across reset produces no press.
    do_reset(7'b0000001);
    step(7'b0000001, 1'b0);
    check("held_hl", 32'(highlight), 32'd0);
    step(7'b0000001, 1'b1);
    check("held_mv",  32'(move_valid), 32'd0);
    check("held_cnt", 32'(move_count), 32'd0);
    step(7'd0, 1'b0);

    // Press coinciding with frame_end: commit waits for the next one.
    step(7'b0000100, 1'b1);
    check("same_hl", 32'(highlight),  32'b0000100);
    check("same_mv", 32'(move_valid), 32'd0);
    step(7'd0, 1'b0);
    check("same_cnt0", 32'(move_count), 32'd0);
    step(7'd0, 1'b1);
    check("same_mv2",  32'(move_valid), 32'd1);
    check("same_cnt1", 32'(move_count), 32'd1);
    step(7'd0, 1'b0);
    check("same_mv3", 32'(move_valid), 32'd0);

    // Reset mid-PENDING drops the move.
    step(7'b0010000, 1'b0);
    do_reset(7'd0);
    #1;
    check("rstpend_hl", 32'(highlight), 32'd0);
    read_cell(4, 0, 2'b00, "rstpend_c4");
    read_cell(2, 0, 2'b00, "rstpend_c2");

    // Fill the whole board column by column.
    step(7'd0, 1'b0);
    for (int k = 0; k < MAX_MOVES; k++) begin
      move(k / ROWS, $sformatf("fill%0d", k));
      check($sformatf("fill%0d_cnt", k), 32'(move_count), 32'(k + 1));
      check($sformatf("fill%0d_full", k), 32'(board_full), 32'(k == MAX_MOVES - 1));
    end
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        read_cell(c, r, ((c * ROWS + r) % 2 == 0) ? 2'b01 : 2'b10, $sformatf("fb_c%0dr%0d", c, r));
    step(7'b0000001, 1'b0);
    check("done_hl", 32'(highlight), 32'd0);
    step(7'd0, 1'b1);
    check("done_mv",   32'(move_valid), 32'd0);
    check("done_cnt",  32'(move_count), 32'd42);
    check("done_full", 32'(board_full), 32'd1);

    do_reset(7'd0);
    #1;
    check("end_hl",   32'(highlight),  32'd0);
    check("end_turn", 32'(turn),       32'd0);
    check("end_cnt",  32'(move_count), 32'd0);
    check("end_mc",   32'(move_col),   32'd0);
    check("end_full", 32'(board_full), 32'd0);
    read_cell(6, 5, 2'b00, "end_c6r5");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/column_drop_controller.md
# column_drop_controller

Game-state controller for the 7-column drop board rendered by the VGA drawer. It turns column key presses into piece drops, arbitrating simultaneous presses and rejecting presses on full columns. It commits moves only at frame end, so the picture never tears mid-frame. It owns the 7x6 board, turn and move count, and drives the drawer's column-highlight input and a cell read port.

## Interface
Parameters:
- COLS, 7, number of board columns (91 px wide each in the drawer)
- ROWS, 6, number of rows per column

Ports:
- clk  in  1  pixel-domain clock
- reset  in  1  synchronous, active-high
- key_in  in  COLS  raw column keys, active-high, already synchronized to clk
- frame_end  in  1  one-cycle pulse at start of vertical blanking
- rd_col  in  3  cell read column
- rd_row  in  3  cell read row (0 = bottom)
- rd_cell  out  2  combinational cell contents: 00 empty, 01 player 1, 10 player 2
- highlight  out  COLS  one-hot pending column, drives drawer keyArray; 0 when none
- turn  out  1  player to move: 0 = player 1, 1 = player 2
- move_count  out  6  pieces placed, 0..42
- move_valid  out  1  one-cycle pulse, cycle after a commit
- move_col  out  3  column of last committed move, valid with move_valid
- board_full  out  1  high in DONE

## Operation
- Edge detect: key_prev register; rise = key_in & ~key_prev. key_prev resets to all ones, so a key held through reset never counts as a press.
- Arbitration: among rise bits in one cycle, lowest index wins. All other rise bits that cycle are discarded, not queued.
- Column height counters h[c] (3 bits, 0..ROWS). A column with h[c]==ROWS is full.
- FSM states:
  - IDLE: a winning rise on a non-full column latches pend_col and moves to PENDING. A rise on a full column is ignored, stay IDLE. frame_end is ignored.
  - PENDING: highlight = 1<<pend_col. All rises are ignored; no re-selection.
  - PENDING with frame_end = 1: commit. board[pend_col][h[pend_col]] = turn+1, h[pend_col]++, move_count++, turn toggles, move_col = pend_col, move_valid set for the next cycle. Next state is DONE if the new move_count==42, else IDLE.
  - DONE: board_full=1, highlight=0, keys ignored. Only reset exits.
- rd_cell: returns 00 when rd_col>=COLS or rd_row>=ROWS.
- Reset values: board all 00, h all 0, turn 0, move_count 0, move_valid 0, move_col 0, highlight 0, board_full 0, state IDLE.

## Timing
- Key rise sampled at edge t: state=PENDING and highlight valid after edge t, i.e. visible in cycle t+1.
- Key rise and frame_end in the same IDLE cycle: the press is accepted, but that frame_end is not consumed. Commit waits for the next frame_end.
- frame_end sampled at edge f in PENDING:
  - board, h, turn and move_count update at edge f.
  - move_valid is high for exactly cycle f+1.
  - highlight returns to 0 from cycle f+1.
  - A new press can be accepted at edge f+1.
- Throughput: at most one move per frame.
- Reset mid-PENDING: the pending move is dropped and nothing is written.
- move_count width 6: maximum value 42, never wraps.
- Row index written equals the old h value. Row 0 fills first.

## Structure
- Package column_drop_pkg:
  - COLS and ROWS constants
  - MAX_MOVES = COLS*ROWS
  - cell_t enum {EMPTY=2'b00, P1=2'b01, P2=2'b10}
  - state_t enum {IDLE, PENDING, DONE}
- Sub-module key_edge_arbiter:
  - holds key_prev and the rise detect
  - lowest-index priority encoder
  - outputs req (1 bit) and req_col (3 bits)
- The top holds the FSM, the height counters and the board array.

## Test plan
- Reset, then pulse key_in=7'b0000100, then frame_end: highlight=7'b0000100 until commit; move_valid pulses with move_col=2. rd_cell(2,0)=01, turn=1, move_count=1.
- key_in=7'b1010010 rising in one cycle: pend_col=1. After frame_end only column 1 changes; columns 4 and 6 stay empty.
- Six alternating moves into column 3, then a seventh press on column 3: rows 0..5 read 01,10,01,10,01,10. The seventh press leaves state IDLE, highlight=0 and no move_valid.
- Press column 0, then press column 5 before frame_end: the second press is ignored and only column 0 is written.
- Key held high across reset: no move occurs. Press in the same cycle as frame_end: the commit occurs only on the following frame_end.
- Fill all 42 cells: board_full=1, move_count=42. Further presses are ignored. Reset clears all outputs to their reset values.
